test_port_writer: RTL

TEST_PORT_WRITER -- requirements
Module: test_port_writer

---
 rtl/test_port_writer_pkg.sv | 34 +++
 rtl/test_port_writer_if.sv | 17 +
 rtl/test_port_writer_fib_seq_gen.sv | 52 +++++
 rtl/test_port_writer.sv | 118 +++++++++++
 4 files changed

// File: rtl/test_port_writer_pkg.sv
// -----------------------------------------------------------------------------
// test_port_writer_pkg
// Shared constants and types for the test-port writer and anything that checks
// its output stream.
//   state_t      : writer FSM states (IDLE, WRITE, GAP, DONE)
//   TEST_PORT    : word address every write of a run goes to
//   BEGIN_SYMBOL : first word of a run
//   END_SYMBOL   : last word of a run
//   FIB_LAST     : index of the largest Fibonacci term sent
//   RUN_WORDS    : words per run (begin + ascending + descending + end)
// -----------------------------------------------------------------------------
package test_port_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [29:0] TEST_PORT    = 30'h40;
  localparam logic [31:0] BEGIN_SYMBOL = 32'h0000_0932;
  localparam logic [31:0] END_SYMBOL   = 32'h0000_0D5D;
  localparam int          FIB_LAST     = 15;
  localparam int          CNT_W        = 6;

  // Begin word, F(0)..F(last) up, F(last)..F(0) down, end word.
  function automatic int run_words(input int fib_last);
    return 2 * (fib_last + 1) + 2;
  endfunction

  localparam int RUN_WORDS = run_words(FIB_LAST);

endpackage

// File: rtl/test_port_writer_if.sv
// -----------------------------------------------------------------------------
// test_port_writer_if
// Memory-side write bus of the test-port writer.
//   addr  : word address of the current write (master -> slave)
//   data  : write data                         (master -> slave)
//   wen   : write enable                       (master -> slave)
//   stall : write not accepted while high      (slave  -> master)
// -----------------------------------------------------------------------------
interface test_port_writer_if;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        stall;

  modport master (output addr, output data, output wen, input stall);
  modport slave  (input addr, input data, input wen, output stall);
endinterface

// File: rtl/test_port_writer_fib_seq_gen.sv
// -----------------------------------------------------------------------------
// fib_seq_gen
// Holds the Fibonacci pair fa/fb and walks it up, turns once, then walks it
// back down.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset (fa=0, fb=1)
//   init : restart the sequence at fa=0, fb=1 (ascending)
//   step : advance one term
//   dir  : 0 = ascending, 1 = descending (first descending step is the turn)
//   fa   : current term
// -----------------------------------------------------------------------------
module fib_seq_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        step,
  input  logic        dir,
  output logic [31:0] fa
);

  logic [31:0] fa_reg;
  logic [31:0] fb_reg;
  logic        desc_reg;  // turn already taken in this run

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fa_reg   <= 32'd0;
      fb_reg   <= 32'd1;
      desc_reg <= 1'b0;
    end else if (init) begin
      fa_reg   <= 32'd0;
      fb_reg   <= 32'd1;
      desc_reg <= 1'b0;
    end else if (step) begin
      if (!dir) begin
        fa_reg <= fb_reg;
        fb_reg <= fa_reg + fb_reg;
      end else if (!desc_reg) begin
        // Turn: the top term is sent twice, so fa holds and fb drops to the
        // term below it.
        fb_reg   <= fb_reg - fa_reg;
        desc_reg <= 1'b1;
      end else begin
        fa_reg <= fb_reg;
        fb_reg <= fa_reg - fb_reg;
      end
    end
  end

  assign fa = fa_reg;

endmodule

// File: rtl/test_port_writer.sv
// -----------------------------------------------------------------------------
// test_port_writer
// On start, writes one run of words to TEST_PORT: BEGIN_SYMBOL, F(0)..F(last),
// F(last)..F(0), END_SYMBOL. Each write waits out stall, then one idle (GAP)
// cycle separates it from the next.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   start : one-cycle run request, honoured in IDLE and DONE
//   busy  : high from start acceptance until the last write is accepted
//   done  : high after a full run until reset or the next start
//   bus   : write bus (addr, data, wen out; stall in)
// -----------------------------------------------------------------------------
module test_port_writer #(
  parameter logic [29:0] TEST_PORT    = test_port_writer_pkg::TEST_PORT,
  parameter logic [31:0] BEGIN_SYMBOL = test_port_writer_pkg::BEGIN_SYMBOL,
  parameter logic [31:0] END_SYMBOL   = test_port_writer_pkg::END_SYMBOL,
  parameter int          FIB_LAST     = test_port_writer_pkg::FIB_LAST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  test_port_writer_if.master         bus
);

  import test_port_writer_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(run_words(FIB_LAST) - 1);
  localparam logic [CNT_W-1:0] TURN_IDX = CNT_W'(FIB_LAST + 1);
  // Fibonacci words 1..LAST_IDX-2 advance the generator once accepted;
  // the final F(0) word needs no successor.
  localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(run_words(FIB_LAST) - 3);

  state_t           state_reg;
  logic [CNT_W-1:0] word_cnt_reg;
  logic [29:0]      addr_reg;
  logic [31:0]      data_reg;
  logic             wen_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             start_ok;
  logic             accept;
  logic             fib_init;
  logic             fib_step;
  logic             fib_dir;
  logic [31:0]      fib_a;

  assign start_ok = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign accept   = (state_reg == ST_WRITE) && !bus.stall;
  assign fib_init = start_ok;
  assign fib_step = accept && (word_cnt_reg != '0) && (word_cnt_reg <= STEP_MAX);
  assign fib_dir  = (word_cnt_reg >= TURN_IDX);

  fib_seq_gen u_fib (
    .clk  (clk),
    .rst  (rst),
    .init (fib_init),
    .step (fib_step),
    .dir  (fib_dir),
    .fa   (fib_a)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      wen_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg    <= ST_WRITE;
            word_cnt_reg <= '0;
            addr_reg     <= TEST_PORT;
            data_reg     <= BEGIN_SYMBOL;
            wen_reg      <= 1'b1;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
          end
        end
        ST_WRITE: begin
          // Under stall every bus register simply holds.
          if (!bus.stall) begin
            wen_reg <= 1'b0;
            if (word_cnt_reg == LAST_IDX) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg    <= ST_GAP;
              word_cnt_reg <= word_cnt_reg + 1'b1;
            end
          end
        end
        ST_GAP: begin
          // Counter and generator already point at the next word here.
          state_reg <= ST_WRITE;
          wen_reg   <= 1'b1;
          data_reg  <= (word_cnt_reg == LAST_IDX) ? END_SYMBOL : fib_a;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.addr = addr_reg;
  assign bus.data = data_reg;
  assign bus.wen  = wen_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule
